// File: rtl/alu_arbiter_if.sv
// Bundle of the requester, ALU and response signals around the ALU arbiter.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface alu_arbiter_if;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [1:0] req_cin;

  logic       alu_start;
  logic [3:0] alu_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic       alu_cin;
  logic       alu_done;
  logic [3:0] alu_result;
  logic       alu_carry;
  logic       alu_zero;

  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [3:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_zero;
  logic       rsp_err;

  modport master (
    input  req_valid, req_op, req_a, req_b, req_cin,
    output req_ready,
    output alu_start, alu_op, alu_a, alu_b, alu_cin,
    input  alu_done, alu_result, alu_carry, alu_zero,
    output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_err,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_op, req_a, req_b, req_cin,
    input  req_ready,
    input  alu_start, alu_op, alu_a, alu_b, alu_cin,
    output alu_done, alu_result, alu_carry, alu_zero,
    input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared ALU, with an abort on ALU timeout.
module alu_arbiter #(
  parameter int unsigned TIMEOUT = 8  // legal 2..255
) (
  input logic           clk1,
  input logic           rst_n,
  alu_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       last_grant_q, last_grant_d;
  logic [3:0] alu_op_q, alu_op_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic       alu_cin_q, alu_cin_d;
  logic       rsp_id_q, rsp_id_d;
  logic [3:0] rsp_result_q, rsp_result_d;
  logic       rsp_carry_q, rsp_carry_d;
  logic       rsp_zero_q, rsp_zero_d;
  logic       rsp_err_q, rsp_err_d;

  logic grant;
  logic hs;

  // Round-robin pick; with a lone requester the grant simply follows it.
  always_comb begin
    if (&bus.req_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = bus.req_valid[1];
    end
    // req_ready is only raised for a valid requester, so any valid in IDLE is a handshake.
    hs = (state_q == StIdle) && (|bus.req_valid);
  end

  // State register.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; alu_done wins over an expiring timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (hs) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (bus.alu_done || (cnt_q == CntLast)) state_d = StResp;
      StResp:  if (bus.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.req_ready = 2'b00;
    if (hs) begin
      bus.req_ready = grant ? 2'b10 : 2'b01;
    end
    bus.alu_start = (state_q == StIssue);
    bus.rsp_valid = (state_q == StResp);
  end

  // Datapath next-state: operand latch, timeout counter, response capture, fairness pointer.
  always_comb begin
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_cin_d    = alu_cin_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (hs) begin
          alu_op_d  = grant ? bus.req_op[7:4] : bus.req_op[3:0];
          alu_a_d   = grant ? bus.req_a[7:4]  : bus.req_a[3:0];
          alu_b_d   = grant ? bus.req_b[7:4]  : bus.req_b[3:0];
          alu_cin_d = bus.req_cin[grant];
          rsp_id_d  = grant;
        end
      end
      StIssue: cnt_d = 8'd0;
      StWait: begin
        if (bus.alu_done) begin
          rsp_result_d = bus.alu_result;
          rsp_carry_d  = bus.alu_carry;
          rsp_zero_d   = bus.alu_zero;
          rsp_err_d    = 1'b0;
        end else if (cnt_q == CntLast) begin
          rsp_result_d = 4'd0;
          rsp_carry_d  = 1'b0;
          rsp_zero_d   = 1'b0;
          rsp_err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp: if (bus.rsp_ready) last_grant_d = rsp_id_q;
      default: ;
    endcase
  end

  // Datapath registers; last_grant resets to 1 so requester 0 wins first contention.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= 8'd0;
      last_grant_q <= 1'b1;
      alu_op_q     <= 4'd0;
      alu_a_q      <= 4'd0;
      alu_b_q      <= 4'd0;
      alu_cin_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 4'd0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_cin_q    <= alu_cin_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.alu_op     = alu_op_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_cin    = alu_cin_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: single request, contention, timeout, collision,
// backpressure and reset mid-operation.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;

  alu_arbiter_if bus ();

  alu_arbiter #(.TIMEOUT(8)) dut (
    .clk1  (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic g;
    bus.req_valid  = 2'b00;
    bus.req_op     = 8'h00;
    bus.req_a      = 8'h00;
    bus.req_b      = 8'h00;
    bus.req_cin    = 2'b00;
    bus.alu_done   = 1'b0;
    bus.alu_result = 4'h0;
    bus.alu_carry  = 1'b0;
    bus.alu_zero   = 1'b0;
    bus.rsp_ready  = 1'b0;

    // Reset values.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 8'(bus.rsp_valid), 8'd0);
    chk("rst_alu_start", 8'(bus.alu_start), 8'd0);
    chk("rst_alu_op", 8'(bus.alu_op), 8'd0);
    chk("rst_rsp_err", 8'(bus.rsp_err), 8'd0);
    chk("rst_req_ready", 8'(bus.req_ready), 8'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single request from requester 0: 5 + 3.
    bus.req_valid = 2'b01;
    bus.req_op    = 8'h02;
    bus.req_a     = 8'h05;
    bus.req_b     = 8'h03;
    #1;
    chk("single_ready", 8'(bus.req_ready), 8'h01);
    tick();
    bus.req_valid = 2'b00;
    #1;
    chk("single_start", 8'(bus.alu_start), 8'd1);
    chk("single_op", 8'(bus.alu_op), 8'h2);
    chk("single_a", 8'(bus.alu_a), 8'h5);
    chk("single_b", 8'(bus.alu_b), 8'h3);
    tick();
    chk("single_start_off", 8'(bus.alu_start), 8'd0);
    bus.alu_done   = 1'b1;
    bus.alu_result = 4'h8;
    tick();
    bus.alu_done = 1'b0;
    chk("single_rsp_valid", 8'(bus.rsp_valid), 8'd1);
    chk("single_rsp_id", 8'(bus.rsp_id), 8'd0);
    chk("single_rsp_result", 8'(bus.rsp_result), 8'h8);
    chk("single_rsp_err", 8'(bus.rsp_err), 8'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("single_back_idle", 8'(bus.rsp_valid), 8'd0);

    // Contention after reset: grants alternate 0,1,0,1.
    do_reset();
    bus.req_valid = 2'b11;
    bus.req_op    = 8'h41;
    bus.req_a     = 8'h52;
    bus.req_b     = 8'h63;
    bus.req_cin   = 2'b10;
    #1;
    for (int i = 0; i < 4; i++) begin
      g = 1'(i % 2);
      chk("rr_ready", 8'(bus.req_ready), g ? 8'h02 : 8'h01);
      tick();
      chk("rr_issue_ready", 8'(bus.req_ready), 8'h00);
      chk("rr_start", 8'(bus.alu_start), 8'd1);
      chk("rr_op", 8'(bus.alu_op), g ? 8'h4 : 8'h1);
      chk("rr_cin", 8'(bus.alu_cin), 8'(g));
      tick();
      bus.alu_done   = 1'b1;
      bus.alu_result = 4'(i + 3);
      tick();
      bus.alu_done = 1'b0;
      chk("rr_rsp_id", 8'(bus.rsp_id), 8'(g));
      chk("rr_rsp_result", 8'(bus.rsp_result), 8'(i + 3));
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      #1;
    end
    bus.req_valid = 2'b00;
    bus.req_cin   = 2'b00;

    // Timeout on requester 1 (last grant was 1, but it is the only one valid).
    bus.req_valid = 2'b10;
    bus.req_op    = 8'h70;
    #1;
    chk("to_ready", 8'(bus.req_ready), 8'h02);
    tick();
    bus.req_valid = 2'b00;
    tick();  // now in WAIT with counter 0
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("to_not_yet", 8'(bus.rsp_valid), 8'd0);
    end
    tick();
    chk("to_rsp_valid", 8'(bus.rsp_valid), 8'd1);
    chk("to_rsp_err", 8'(bus.rsp_err), 8'd1);
    chk("to_rsp_result", 8'(bus.rsp_result), 8'h0);
    chk("to_rsp_id", 8'(bus.rsp_id), 8'd1);

    // Backpressure: response held, no new grant or launch.
    bus.req_valid = 2'b11;
    bus.req_op    = 8'h7C;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready", 8'(bus.req_ready), 8'h00);
      chk("bp_start", 8'(bus.alu_start), 8'd0);
      chk("bp_rsp", 8'({bus.rsp_valid, bus.rsp_err, bus.rsp_id, bus.rsp_result}), 8'h70);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    #1;
    chk("bp_idle_valid", 8'(bus.rsp_valid), 8'd0);
    chk("bp_idle_grant", 8'(bus.req_ready), 8'h01);

    // Done arriving on the last timeout cycle wins.
    tick();
    bus.req_valid = 2'b00;
    chk("col_op", 8'(bus.alu_op), 8'hC);
    tick();  // WAIT, counter 0
    for (int i = 1; i < 8; i++) tick();
    bus.alu_done   = 1'b1;
    bus.alu_result = 4'hF;
    bus.alu_carry  = 1'b1;
    tick();
    bus.alu_done  = 1'b0;
    bus.alu_carry = 1'b0;
    chk("col_rsp_valid", 8'(bus.rsp_valid), 8'd1);
    chk("col_rsp_err", 8'(bus.rsp_err), 8'd0);
    chk("col_rsp_result", 8'(bus.rsp_result), 8'hF);
    chk("col_rsp_carry", 8'(bus.rsp_carry), 8'd1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Reset while in WAIT, then a late alu_done must be ignored.
    bus.req_valid = 2'b10;
    bus.req_op    = 8'h72;
    bus.req_a     = 8'h90;
    tick();
    bus.req_valid = 2'b00;
    chk("mid_op", 8'(bus.alu_op), 8'h7);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_op", 8'(bus.alu_op), 8'h0);
    chk("mid_rst_a", 8'(bus.alu_a), 8'h0);
    chk("mid_rst_id", 8'(bus.rsp_id), 8'd0);
    chk("mid_rst_result", 8'(bus.rsp_result), 8'h0);
    chk("mid_rst_carry", 8'(bus.rsp_carry), 8'd0);
    chk("mid_rst_valid", 8'(bus.rsp_valid), 8'd0);
    tick();
    rst_n = 1'b1;
    bus.alu_done   = 1'b1;
    bus.alu_result = 4'h6;
    tick();
    bus.alu_done = 1'b0;
    chk("late_done_1", 8'(bus.rsp_valid), 8'd0);
    tick();
    chk("late_done_2", 8'(bus.rsp_valid), 8'd0);
    chk("late_done_start", 8'(bus.alu_start), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT, 8, max cycles in WAIT before abort (legal 2..255).
REQ-002 SHALL have ports, one per line:
- clk1  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  2  bit i = requester i has an operation pending
- req_ready  output  2  bit i = requester i's operation accepted this cycle
- req_op  input  8  {op1[3:0], op0[3:0]} ALU op codes
- req_a  input  8  {a1, a0} 4-bit operands
- req_b  input  8  {b1, b0} 4-bit operands
- req_cin  input  2  {cin1, cin0}
- alu_start  output  1  one-cycle pulse, ALU launches operation
- alu_op  output  4  latched op code to ALU
- alu_a, alu_b  output  4 each  latched operands to ALU
- alu_cin  output  1  latched carry-in to ALU
- alu_done  input  1  ALU result valid this cycle
- alu_result  input  4  ALU result
- alu_carry, alu_zero  input  1 each  ALU flags
- rsp_valid  output  1  response pending
- rsp_ready  input  1  response consumer accepts
- rsp_id  output  1  requester owning the response
- rsp_result  output  4  result
- rsp_carry, rsp_zero, rsp_err  output  1 each  flags; err = timeout

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-004 SHALL, in IDLE, assert req_ready[g] combinationally for exactly one granted requester g when any req_valid is high; other bit 0; both 0 outside IDLE.
REQ-005 SHALL arbitrate round-robin: both valid -> grant requester not equal to last_grant; one valid -> grant it.
REQ-006 SHALL, on handshake (IDLE, req_valid[g] & req_ready[g]), latch op/a/b/cin of g into alu_op/alu_a/alu_b/alu_cin and rsp_id=g, go ISSUE.
REQ-007 SHALL hold alu_op/alu_a/alu_b/alu_cin stable from latch until next handshake.
REQ-008 SHALL assert alu_start for exactly the single ISSUE cycle, then go WAIT with timeout counter cleared to 0.
REQ-009 SHALL ignore alu_done outside WAIT.
REQ-010 SHALL, in WAIT with alu_done=1, capture alu_result/alu_carry/alu_zero into rsp_result/rsp_carry/rsp_zero, rsp_err=0, go RESP.
REQ-011 SHALL, in WAIT with alu_done=0, increment counter; when counter = TIMEOUT-1 and alu_done=0, set rsp_result=0, rsp_carry=0, rsp_zero=0, rsp_err=1, go RESP.
REQ-012 SHALL give alu_done priority over timeout in the same cycle.
REQ-013 SHALL assert rsp_valid only in RESP; rsp_* stable while rsp_valid=1 and rsp_ready=0.
REQ-014 SHALL, on rsp_valid & rsp_ready, update last_grant=rsp_id and go IDLE; new grant earliest next cycle.
REQ-015 SHALL give minimum latency handshake->rsp_valid of 3 cycles (ISSUE, WAIT with alu_done, RESP).
REQ-016 SHALL not drop or reorder a pending request; a requester deasserting req_valid before grant is not served.

Reset
REQ-017 SHALL on rst_n=0 immediately: state IDLE, alu_start=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry=0, rsp_zero=0, rsp_err=0, alu_op/a/b/cin=0, counter=0, last_grant=1 (requester 0 wins first contention).
REQ-018 SHALL abandon any in-flight operation on reset mid-operation; a late alu_done after reset release in IDLE is ignored.

Verification
REQ-019 Single request: req_valid=01, op0=2, a0=5, b0=3 -> req_ready=01, alu_start one cycle with alu_op=2/a=5/b=3; ALU done result=8 carry=0 -> rsp_valid, rsp_id=0, rsp_result=8, rsp_err=0.
REQ-020 Contention: req_valid=11 held after reset -> grants 0,1,0,1 in order across four completed transactions.
REQ-021 Timeout: TIMEOUT=8, alu_done never asserted -> rsp_valid exactly 8 cycles after WAIT entry with rsp_err=1, rsp_result=0.
REQ-022 Done/timeout collision: alu_done=1 on counter=TIMEOUT-1, result=0xF carry=1 -> rsp_err=0, rsp_result=F, rsp_carry=1.
REQ-023 Backpressure: rsp_ready=0 for 5 cycles -> rsp_* constant, req_ready=00, no alu_start; rsp_ready=1 -> IDLE next cycle.
REQ-024 Reset in WAIT: rst_n low one cycle -> all outputs at reset values; alu_done pulse afterwards produces no rsp_valid.
